// File: rtl/des_pkg.sv
// Shared definitions for the DES key-schedule controller: FSM states, round index type,
// the per-round shift table, the PC-2 selection table and 28-bit rotate helpers.
// Purely declarative: no latency or flow-control behaviour of its own.
package des_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef logic [3:0] round_t;

   localparam round_t LAST_ROUND = 4'd15;

   // Left-shift count per DES round, entry n (1..16) at bits [2*(n-1) +: 2].
   // Listed from entry 16 down to entry 1.
   localparam logic [31:0] SHIFT_TBL = {
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
      2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
   };

   // PC-2: output bit j (1 = MSB) takes input bit PC2_TBL entry j (1 = MSB of {C,D}).
   // First listed entry occupies the top 6 bits.
   localparam logic [287:0] PC2_TBL = {
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   // n is the 1-based DES round number (1..16).
   function automatic logic [1:0] shift_of(input logic [4:0] n);
      logic [3:0] idx;
      idx = 4'(n - 5'd1);
      return SHIFT_TBL[{idx, 1'b0} +: 2];
   endfunction

   // Only shift counts of 1 and 2 occur in the schedule.
   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
      return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
      return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

endpackage

// File: rtl/des_key_sched_ctrl_if.sv
// Key-load, start and subkey-stream signals of the DES key-schedule controller.
// master: key checker / sequencer / round datapath side; slave: the controller.
// Key load has no backpressure; the subkey stream is valid/ready.
interface des_key_sched_ctrl_if;
   import des_pkg::*;

   logic [55:0] key_in;
   logic        key_in_valid;
   logic        key_err_in;
   logic        start_in;
   logic        decrypt_in;
   logic        start_ready_out;
   logic [47:0] subkey_out;
   round_t      round_out;
   logic        subkey_valid_out;
   logic        subkey_ready_in;
   logic        done_out;
   logic        key_loaded_out;

   modport master (
      output key_in, key_in_valid, key_err_in, start_in, decrypt_in, subkey_ready_in,
      input  start_ready_out, subkey_out, round_out, subkey_valid_out, done_out,
             key_loaded_out
   );

   modport slave (
      input  key_in, key_in_valid, key_err_in, start_in, decrypt_in, subkey_ready_in,
      output start_ready_out, subkey_out, round_out, subkey_valid_out, done_out,
             key_loaded_out
   );

endinterface

// File: rtl/des_pc2.sv
// DES permuted choice 2: selects 48 of the 56 bits of {C,D} to form a round subkey.
// Latency: purely combinational. Backpressure: none (pure wiring).
// Ports: cd (56-bit {C,D}, FIPS bit 1 at MSB), subkey (48-bit, FIPS bit 1 at MSB).
module des_pc2
   import des_pkg::*;
(
   input  logic [55:0] cd,
   output logic [47:0] subkey
);

   for (genvar j = 0; j < 48; j++) begin : g_bit
      // FIPS bit p (1-based from the MSB) lives at vector index 56-p.
      localparam int SRC = 56 - int'(PC2_TBL[(47 - j) * 6 +: 6]);
      assign subkey[47 - j] = cd[SRC];
   end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule controller: holds a master key and streams 16 PC-2 subkeys per start.
// Latency: first subkey valid the cycle after start acceptance, one subkey per handshake.
// Backpressure: subkey held stable while subkey_ready_in is low; key load is never stalled.
// Ports: clk_in, rst_n_in (async, active-low), bus (slave modport: key load, start, subkey stream).
module des_key_sched_ctrl
   import des_pkg::*;
(
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   des_key_sched_ctrl_if.slave        bus
);

   state_t      state;
   logic [55:0] master_key;
   logic        key_loaded;
   logic [27:0] c_reg;
   logic [27:0] d_reg;
   round_t      round;
   logic        decrypt;
   logic        subkey_valid;
   logic        done;

   logic        start_ready;
   logic        start_acc;
   logic        hshake;
   logic [4:0]  tbl_idx;
   logic [1:0]  rot_amt;
   logic [27:0] c_nxt;
   logic [27:0] d_nxt;
   logic [47:0] subkey;

   // A key arriving this very cycle blocks the start so the schedule never
   // runs from a key that is about to be replaced or rejected.
   assign start_ready = (state == ST_IDLE) & key_loaded & ~bus.key_in_valid;
   assign start_acc   = bus.start_in & start_ready;
   assign hshake      = subkey_valid & bus.subkey_ready_in;

   // Moving from round r to r+1: encrypt applies the shift of DES round r+2
   // (the first shift was applied at load); decrypt undoes the shift of round 16-r.
   always_comb begin
      tbl_idx = 5'd1;
      c_nxt   = c_reg;
      d_nxt   = d_reg;
      if (decrypt) begin
         tbl_idx = 5'd16 - {1'b0, round};
      end else begin
         tbl_idx = {1'b0, round} + 5'd2;
      end
      rot_amt = shift_of(tbl_idx);
      if (decrypt) begin
         c_nxt = rotr28(c_reg, rot_amt);
         d_nxt = rotr28(d_reg, rot_amt);
      end else begin
         c_nxt = rotl28(c_reg, rot_amt);
         d_nxt = rotl28(d_reg, rot_amt);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state        <= ST_IDLE;
         master_key   <= '0;
         key_loaded   <= 1'b0;
         c_reg        <= '0;
         d_reg        <= '0;
         round        <= '0;
         decrypt      <= 1'b0;
         subkey_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;

         // Master key updates in any state; a running schedule only uses c_reg/d_reg.
         if (bus.key_in_valid) begin
            if (!bus.key_err_in) begin
               master_key <= bus.key_in;
               key_loaded <= 1'b1;
            end else begin
               key_loaded <= 1'b0;
            end
         end

         case (state)
            ST_IDLE: begin
               if (start_acc) begin
                  decrypt      <= bus.decrypt_in;
                  round        <= '0;
                  subkey_valid <= 1'b1;
                  state        <= ST_RUN;
                  // Decrypt starts at K16, whose cumulative rotation (28) is the identity.
                  if (bus.decrypt_in) begin
                     c_reg <= master_key[55:28];
                     d_reg <= master_key[27:0];
                  end else begin
                     c_reg <= rotl28(master_key[55:28], 2'd1);
                     d_reg <= rotl28(master_key[27:0], 2'd1);
                  end
               end
            end

            ST_RUN: begin
               if (hshake) begin
                  if (round == LAST_ROUND) begin
                     subkey_valid <= 1'b0;
                     done         <= 1'b1;
                     state        <= ST_DONE;
                  end else begin
                     c_reg <= c_nxt;
                     d_reg <= d_nxt;
                     round <= round + 4'd1;
                  end
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   des_pc2 u_pc2 (
      .cd     ({c_reg, d_reg}),
      .subkey (subkey)
   );

   assign bus.start_ready_out  = start_ready;
   assign bus.subkey_out       = subkey;
   assign bus.round_out        = round;
   assign bus.subkey_valid_out = subkey_valid;
   assign bus.done_out         = done;
   assign bus.key_loaded_out   = key_loaded;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Bench for des_key_sched_ctrl: directed key loads and schedules, with a
// scoreboard queue of expected {round, subkey} popped by a separate monitor.
// Ports: none (top-level bench).
module tb_des_key_sched_ctrl;

   localparam logic [55:0] KEY = 56'hF0CCAAF556678F;

   logic clk_in = 1'b0;
   logic rst_n_in;
   always #5 clk_in = ~clk_in;

   des_key_sched_ctrl_if bus ();

   des_key_sched_ctrl dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus)
   );

   typedef struct packed {
      logic [3:0]  rnd;
      logic [47:0] key;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vld_cycles = 0;
   int   done_cnt = 0;

   // Standard PC-2 positions and cumulative left shifts before DES round i.
   int PC2_POS [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   int CUM [17] = '{0, 1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Subkey K_i computed from the absolute cumulative rotation of C0/D0.
   function automatic logic [47:0] model_key(input logic [55:0] k, input int i);
      logic [27:0] c;
      logic [27:0] d;
      logic [55:0] cd;
      logic [47:0] r;
      c  = k[55:28];
      d  = k[27:0];
      c  = (c << CUM[i]) | (c >> (28 - CUM[i]));
      d  = (d << CUM[i]) | (d >> (28 - CUM[i]));
      cd = {c, d};
      r  = '0;
      for (int j = 0; j < 48; j++) r[47 - j] = cd[56 - PC2_POS[j]];
      return r;
   endfunction

   // Published vectors for the known rounds, model for the rest.
   function automatic logic [47:0] ek(input int i);
      case (i)
         1:       return 48'h1B02EFFC7072;
         2:       return 48'h79AED9DBC9E5;
         16:      return 48'hCB3D8B0E17F5;
         default: return model_key(KEY, i);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_idle_zero(input string name);
      chk({name, " start_ready"}, 64'(bus.start_ready_out), 64'd0);
      chk({name, " subkey"},      64'(bus.subkey_out),      64'd0);
      chk({name, " round"},       64'(bus.round_out),       64'd0);
      chk({name, " valid"},       64'(bus.subkey_valid_out), 64'd0);
      chk({name, " done"},        64'(bus.done_out),        64'd0);
      chk({name, " key_loaded"},  64'(bus.key_loaded_out),  64'd0);
   endtask

   task automatic load_key(input logic [55:0] k, input logic err);
      bus.key_in       = k;
      bus.key_err_in   = err;
      bus.key_in_valid = 1'b1;
      #1;
      chk("ready low during key load", 64'(bus.start_ready_out), 64'd0);
      tick();
      bus.key_in_valid = 1'b0;
      bus.key_err_in   = 1'b0;
      #1;
      chk("key_loaded after load", 64'(bus.key_loaded_out), 64'(!err));
      chk("start_ready after load", 64'(bus.start_ready_out), 64'(!err));
   endtask

   task automatic do_start(input logic dec, input bit expect_acc);
      if (expect_acc) begin
         for (int r = 0; r < 16; r++) begin
            sb_q.push_back({4'(r), ek(dec ? 16 - r : r + 1)});
         end
      end
      bus.start_in   = 1'b1;
      bus.decrypt_in = dec;
      chk("start_ready at start", 64'(bus.start_ready_out), 64'(expect_acc));
      tick();
      bus.start_in   = 1'b0;
      bus.decrypt_in = 1'b0;
   endtask

   task automatic wait_done(input int exp_cycles, input string name);
      int d0;
      bit got;
      d0  = done_cnt;
      got = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
      end
      chk({name, " done seen"}, 64'(got), 64'd1);
      chk({name, " valid cycles"}, 64'(vld_cycles), 64'(exp_cycles));
      tick();
      chk({name, " done pulses"}, 64'(done_cnt - d0), 64'd1);
      chk({name, " queue drained"}, 64'(sb_q.size()), 64'd0);
      chk({name, " valid low after"}, 64'(bus.subkey_valid_out), 64'd0);
   endtask

   // Monitor: pops the scoreboard on every handshake, checks hold stability and done.
   initial begin : monitor
      bit          held;
      logic [3:0]  held_rnd;
      logic [47:0] held_key;
      exp_t        e;
      held = 1'b0;
      held_rnd = '0;
      held_key = '0;
      forever begin
         @(negedge clk_in);
         if (!rst_n_in) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("hold stable", 64'({bus.subkey_valid_out, bus.round_out, bus.subkey_out}),
                   64'({1'b1, held_rnd, held_key}));
            end
            if (bus.subkey_valid_out) vld_cycles++;
            if (bus.subkey_valid_out && bus.subkey_ready_in) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious subkey: round %0d subkey %h with nothing expected",
                           bus.round_out, bus.subkey_out);
               end else begin
                  e = sb_q.pop_front();
                  chk($sformatf("subkey r%0d", e.rnd), 64'({bus.round_out, bus.subkey_out}),
                      64'({e.rnd, e.key}));
               end
            end
            held     = bus.subkey_valid_out && !bus.subkey_ready_in;
            held_rnd = bus.round_out;
            held_key = bus.subkey_out;
            if (bus.done_out) begin
               done_cnt++;
               chk("valid low with done", 64'(bus.subkey_valid_out), 64'd0);
            end
         end
      end
   end

   initial begin : stimulus
      rst_n_in             = 1'b0;
      bus.key_in           = '0;
      bus.key_in_valid     = 1'b0;
      bus.key_err_in       = 1'b0;
      bus.start_in         = 1'b0;
      bus.decrypt_in       = 1'b0;
      bus.subkey_ready_in  = 1'b1;
      repeat (3) tick();
      rst_n_in = 1'b1;
      #1;
      check_idle_zero("reset");

      // Start with no key loaded is ignored.
      do_start(1'b0, 1'b0);
      repeat (4) tick();
      chk("no key start valid", 64'(bus.subkey_valid_out), 64'd0);

      // Rejected key.
      load_key(KEY, 1'b1);
      do_start(1'b0, 1'b0);
      repeat (3) tick();
      chk("bad key start valid", 64'(bus.subkey_valid_out), 64'd0);

      // Good key, then a bad key clears key_loaded, then good again.
      load_key(KEY, 1'b0);
      load_key(56'h1, 1'b1);
      load_key(KEY, 1'b0);

      // Encrypt, with a start pulse mid-run that must not be remembered.
      vld_cycles = 0;
      do_start(1'b0, 1'b1);
      repeat (3) tick();
      bus.start_in = 1'b1;
      chk("ready low in run", 64'(bus.start_ready_out), 64'd0);
      tick();
      bus.start_in = 1'b0;
      wait_done(16, "enc");
      repeat (3) tick();
      chk("no restart after enc", 64'(bus.subkey_valid_out), 64'd0);

      // Decrypt, with a new key arriving mid-run that must not disturb it.
      vld_cycles = 0;
      do_start(1'b1, 1'b1);
      repeat (4) tick();
      bus.key_in       = '0;
      bus.key_in_valid = 1'b1;
      tick();
      bus.key_in_valid = 1'b0;
      wait_done(16, "dec");
      chk("key_loaded after run load", 64'(bus.key_loaded_out), 64'd1);
      load_key(KEY, 1'b0);

      // Backpressure for 3 cycles at round 5.
      vld_cycles = 0;
      do_start(1'b0, 1'b1);
      repeat (5) tick();
      chk("bp round at stall", 64'(bus.round_out), 64'd5);
      bus.subkey_ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bp round held %0d", i), 64'(bus.round_out), 64'd5);
      end
      bus.subkey_ready_in = 1'b1;
      wait_done(19, "bp");

      // Reset at round 7.
      do_start(1'b0, 1'b1);
      repeat (7) tick();
      chk("round before reset", 64'(bus.round_out), 64'd7);
      rst_n_in = 1'b0;
      #1;
      check_idle_zero("mid reset");
      sb_q.delete();
      repeat (2) tick();
      rst_n_in = 1'b1;
      tick();
      do_start(1'b0, 1'b0);
      repeat (4) tick();
      chk("post reset start valid", 64'(bus.subkey_valid_out), 64'd0);
      load_key(KEY, 1'b0);
      vld_cycles = 0;
      do_start(1'b0, 1'b1);
      wait_done(16, "post reset enc");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
